emu_time_sched: RTL

Central timestep scheduler for the emulator: gathers timestep requests from N analog blocks, grants the smallest as the global `emu_dt`, and advances `emu_time` by it every emulation cycle. It also handles host run/halt control with an optional stop time, and issues the decimation strobe that gates probe sampling. It sits between the host control registers and every analog model in the emulation top level.

---
 rtl/emu_time_pkg.sv | 13 +
 rtl/emu_dt_min.sv | 34 +++
 rtl/emu_time_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/emu_time_pkg.sv
// Shared types for the emulation timestep scheduler.
// State encoding is fixed because the host reads it back directly.
package emu_time_pkg;

    localparam int unsigned STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } emu_time_state_t;

endpackage

// File: rtl/emu_dt_min.sv
// Combinational minimum over the valid timestep requests.
// Falls back to DT_MAX when no requester is valid.
module emu_dt_min #(
    parameter int unsigned         N_REQ    = 4,
    parameter int unsigned         DT_WIDTH = 24,
    parameter logic [DT_WIDTH-1:0] DT_MAX   = {DT_WIDTH{1'b1}}
) (
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    input  logic [N_REQ-1:0]          dt_req_vld,
    output logic [DT_WIDTH-1:0]       dt_min
);

    // Heap-ordered binary tree; unused and invalid leaves hold DT_MAX.
    localparam int unsigned LEAVES = 1 << $clog2(N_REQ);

    logic [DT_WIDTH-1:0] node [1:2*LEAVES-1];

    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            node[LEAVES+i] = DT_MAX;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (dt_req_vld[i]) begin
                node[LEAVES+i] = dt_req[i*DT_WIDTH +: DT_WIDTH];
            end
        end
        for (int i = LEAVES - 1; i >= 1; i--) begin
            node[i] = (node[2*i+1] < node[2*i]) ? node[2*i+1] : node[2*i];
        end
    end

    assign dt_min = node[1];

endmodule

// File: rtl/emu_time_sched.sv
// Global timestep scheduler: grants the smallest requested step, advances emulation
// time, handles run/halt with an optional stop time, and strobes probe decimation.
module emu_time_sched
    import emu_time_pkg::*;
#(
    parameter int unsigned         N_REQ      = 4,
    parameter int unsigned         TIME_WIDTH = 40,
    parameter int unsigned         DT_WIDTH   = 24,
    parameter int unsigned         DEC_WIDTH  = 16,
    parameter logic [DT_WIDTH-1:0] DT_MAX     = {DT_WIDTH{1'b1}}
) (
    input  logic                      emu_clk,
    input  logic                      emu_rst_n,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    input  logic [N_REQ-1:0]          dt_req_vld,
    input  logic                      run_req,
    input  logic                      stop_en,
    input  logic [TIME_WIDTH-1:0]     stop_time,
    input  logic [DEC_WIDTH-1:0]      dec_thr,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic                      emu_step,
    output logic                      emu_dec_cmp,
    output logic                      halted,
    output logic [STATE_WIDTH-1:0]    state
);

    emu_time_state_t       state_q, state_d;
    logic [TIME_WIDTH-1:0] emu_time_q, emu_time_d;
    logic [DEC_WIDTH-1:0]  dec_cnt_q, dec_cnt_d;

    logic [DT_WIDTH-1:0]   dt_min;
    logic [TIME_WIDTH-1:0] dt_ext;
    logic [TIME_WIDTH-1:0] dt_full;
    logic [TIME_WIDTH:0]   time_sum;
    logic                  stop_hit;
    logic                  time_ovf;
    logic                  halt_hit;

    emu_dt_min #(
        .N_REQ    (N_REQ),
        .DT_WIDTH (DT_WIDTH),
        .DT_MAX   (DT_MAX)
    ) u_dt_min (
        .dt_req     (dt_req),
        .dt_req_vld (dt_req_vld),
        .dt_min     (dt_min)
    );

    // Step selection: stop clip wins over overflow clip since it is never larger.
    always_comb begin
        dt_ext   = TIME_WIDTH'(dt_min);
        time_sum = {1'b0, emu_time_q} + {1'b0, dt_ext};
        stop_hit = stop_en && (time_sum >= {1'b0, stop_time});
        time_ovf = time_sum[TIME_WIDTH];
        emu_step = (state_q == RUN) && run_req;
        dt_full  = '0;
        if (emu_step) begin
            if (stop_hit) begin
                // Already at or past the stop time: take a zero step, then halt.
                dt_full = (emu_time_q >= stop_time) ? '0 : stop_time - emu_time_q;
            end else if (time_ovf) begin
                dt_full = ~emu_time_q;
            end else begin
                dt_full = dt_ext;
            end
        end
        halt_hit   = emu_step && (stop_hit || time_ovf);
        emu_time_d = emu_time_q + dt_full;
    end

    assign emu_dt = dt_full[DT_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (run_req) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!run_req) begin
                    state_d = IDLE;
                end else if (halt_hit) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (!run_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lowering dec_thr below the count lets the counter wrap through all-ones.
    always_comb begin
        emu_dec_cmp = emu_step && (dec_cnt_q == dec_thr);
        dec_cnt_d   = dec_cnt_q;
        if (emu_step) begin
            dec_cnt_d = emu_dec_cmp ? '0 : dec_cnt_q + DEC_WIDTH'(1);
        end
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q    <= IDLE;
            emu_time_q <= '0;
            dec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            emu_time_q <= emu_time_d;
            dec_cnt_q  <= dec_cnt_d;
        end
    end

    assign emu_time = emu_time_q;
    assign halted   = (state_q == HALT);
    assign state    = state_q;

endmodule
